// File: rtl/segway_pkg.sv
// Shared types and defaults for the Segway BLE authorization path.
// Holds the auth/receiver state enums and the UART/command defaults.
package segway_pkg;

  localparam int         BAUD_DIV_DEF  = 2604;
  localparam logic [7:0] GO_CODE_DEF   = 8'h47;
  localparam logic [7:0] STOP_CODE_DEF = 8'h53;

  typedef enum logic [1:0] {
    AUTH_OFF  = 2'd0,
    AUTH_PWR1 = 2'd1,
    AUTH_PWR2 = 2'd2
  } auth_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/UART_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling.
// Ports: clk, rst_n, RX, clr_rdy in; rx_data[7:0], rdy, frm_err out.
module UART_rx
  import segway_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam int            CW   = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  rx_state_t     r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  logic [CW-1:0] r_baud_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_data;
  logic          r_rdy;
  logic          r_frm_err;
  logic          w_rx;
  logic          w_fall;

  assign w_rx   = r_sync2;
  // r_sync3 only remembers the previous synchronized level for edge detect
  assign w_fall = r_sync3 & ~r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync3    <= 1'b1;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_sync1   <= RX;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_frm_err <= 1'b0;
      if (clr_rdy) r_rdy <= 1'b0;
      unique case (r_state)
        RX_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= 4'd0;
          if (w_fall) r_state <= RX_START;
        end
        RX_START: begin
          if (r_baud_cnt == HALF) begin
            r_baud_cnt <= '0;
            // a high level here was a glitch, not a start bit
            r_state    <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + ONE;
          end
        end
        RX_DATA: begin
          if (r_baud_cnt == FULL) begin
            r_baud_cnt <= '0;
            r_shift    <= {w_rx, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) r_state <= RX_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + ONE;
          end
        end
        RX_STOP: begin
          if (r_baud_cnt == FULL) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_state    <= RX_IDLE;
            if (w_rx) begin
              r_rx_data <= r_shift;
              r_rdy     <= 1'b1;
            end else begin
              r_frm_err <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + ONE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;

endmodule

// File: rtl/ble_auth.sv
// BLE authorization: UART command bytes gate rider power-up/shutdown.
// Ports: clk, rst_n, RX, rider_off in; pwr_up, cmd_err, rx_byte[7:0] out.
module ble_auth
  import segway_pkg::*;
#(
  parameter int         BAUD_DIV  = BAUD_DIV_DEF,
  parameter logic [7:0] GO_CODE   = GO_CODE_DEF,
  parameter logic [7:0] STOP_CODE = STOP_CODE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic       cmd_err,
  output logic [7:0] rx_byte
);

  auth_state_t r_state;
  logic        r_pwr_up;
  logic        r_cmd_err;
  logic [7:0]  w_rx_data;
  logic        w_rdy;
  logic        w_frm_err;
  logic        w_go;
  logic        w_stop;
  logic        w_bad;

  // rdy is self-clearing: it lives for exactly one clock
  UART_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(w_rdy),
    .rx_data(w_rx_data),
    .rdy    (w_rdy),
    .frm_err(w_frm_err)
  );

  assign w_go   = w_rdy & (w_rx_data == GO_CODE);
  assign w_stop = w_rdy & (w_rx_data == STOP_CODE);
  assign w_bad  = w_rdy & ~w_go & ~w_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= AUTH_OFF;
      r_pwr_up  <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_frm_err | w_bad;
      r_pwr_up  <= (r_state != AUTH_OFF);
      unique case (r_state)
        AUTH_OFF: begin
          if (w_go) r_state <= AUTH_PWR1;
        end
        AUTH_PWR1: begin
          if (w_stop) r_state <= rider_off ? AUTH_OFF : AUTH_PWR2;
        end
        AUTH_PWR2: begin
          // GO wins over a simultaneous rider_off
          if (w_go)           r_state <= AUTH_PWR1;
          else if (rider_off) r_state <= AUTH_OFF;
        end
        default: r_state <= AUTH_OFF;
      endcase
    end
  end

  assign pwr_up  = r_pwr_up;
  assign cmd_err = r_cmd_err;
  assign rx_byte = w_rx_data;

endmodule
